// File: rtl/quiz_buzz_arbiter.sv
// Quiz buzzer arbiter: locks in the first eligible press, times the answer
// window and applies host judgement to four saturating score registers.
module quiz_buzz_arbiter #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned ANSWER_SECS   = 10,
    parameter int unsigned CORRECT_PTS   = 2,
    parameter int unsigned WRONG_PTS     = 1,
    parameter int unsigned BUZZ_CYCLES   = 20000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [2:0]  player_count_i,
    input  logic [3:0]  player_press_i,
    input  logic        host_start_i,
    input  logic        host_correct_i,
    input  logic        host_wrong_i,
    input  logic        host_cancel_i,
    input  logic        clear_scores_i,
    output logic [1:0]  state_o,
    output logic [2:0]  winner_o,
    output logic [3:0]  locked_o,
    output logic [3:0]  time_left_o,
    output logic [6:0]  player1_score_o,
    output logic [6:0]  player2_score_o,
    output logic [6:0]  player3_score_o,
    output logic [6:0]  player4_score_o,
    output logic [23:0] led_o,
    output logic        buzzer_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StAnswer = 2'd2
    } state_e;

    localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned BuzzW = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;

    localparam logic [TickW-1:0] TickMax    = TickW'(TICKS_PER_SEC - 1);
    localparam logic [BuzzW-1:0] BuzzLoad   = BuzzW'(BUZZ_CYCLES);
    localparam logic [3:0]       AnswerSecs = 4'(ANSWER_SECS);
    localparam logic [7:0]       CorrectPts = 8'(CORRECT_PTS);
    localparam logic [7:0]       WrongPts   = 8'(WRONG_PTS);
    localparam logic [7:0]       ScoreMax   = 8'd99;

    state_e           state_q;
    logic [2:0]       winner_q;
    logic [3:0]       locked_q;
    logic [3:0]       time_left_q;
    logic [TickW-1:0] tick_q;
    logic [BuzzW-1:0] buzz_q;
    logic [6:0]       score_q [4];

    logic [3:0] valid_mask;
    logic [3:0] elig_mask;
    logic [3:0] press_elig;
    logic [3:0] win_onehot;
    logic [3:0] locked_after_wrong;
    logic [2:0] first_idx;
    logic [1:0] win_sel;
    logic [7:0] cur_score;
    logic [7:0] score_up;
    logic [7:0] score_dn;
    logic       tick_wrap;
    logic       timeout;

    always_comb begin
        case (player_count_i)
            3'd0, 3'd1: valid_mask = 4'b0001;
            3'd2:       valid_mask = 4'b0011;
            3'd3:       valid_mask = 4'b0111;
            default:    valid_mask = 4'b1111;
        endcase
        elig_mask  = valid_mask & ~locked_q;
        press_elig = player_press_i & elig_mask;

        // Lowest index wins on simultaneous presses.
        if (press_elig[0])      first_idx = 3'd1;
        else if (press_elig[1]) first_idx = 3'd2;
        else if (press_elig[2]) first_idx = 3'd3;
        else if (press_elig[3]) first_idx = 3'd4;
        else                    first_idx = 3'd0;

        win_sel            = 2'(winner_q - 3'd1);
        win_onehot         = (winner_q != 3'd0) ? (4'b0001 << win_sel) : 4'b0000;
        locked_after_wrong = locked_q | win_onehot;

        // Widened to 8 bits so a large add cannot wrap before saturation.
        cur_score = {1'b0, score_q[win_sel]};
        score_up  = cur_score + CorrectPts;
        if (score_up > ScoreMax) begin
            score_up = ScoreMax;
        end
        score_dn = (cur_score < WrongPts) ? 8'd0 : (cur_score - WrongPts);

        tick_wrap = (tick_q == TickMax);
        timeout   = tick_wrap && (time_left_q == 4'd1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            winner_q    <= 3'd0;
            locked_q    <= 4'd0;
            time_left_q <= 4'd0;
            tick_q      <= '0;
            buzz_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                score_q[i] <= 7'd0;
            end
        end else if (!enable_i) begin
            state_q     <= StIdle;
            winner_q    <= 3'd0;
            locked_q    <= 4'd0;
            time_left_q <= 4'd0;
            tick_q      <= '0;
            buzz_q      <= '0;
        end else begin
            buzz_q <= (buzz_q != '0) ? (buzz_q - BuzzW'(1)) : '0;
            case (state_q)
                StIdle: begin
                    if (clear_scores_i) begin
                        for (int i = 0; i < 4; i++) begin
                            score_q[i] <= 7'd0;
                        end
                    end
                    if (host_start_i) begin
                        state_q <= StArmed;
                    end else begin
                        locked_q <= locked_q | press_elig;
                    end
                end
                StArmed: begin
                    if (host_cancel_i) begin
                        locked_q <= 4'd0;
                        state_q  <= StIdle;
                    end else if (press_elig != 4'd0) begin
                        winner_q    <= first_idx;
                        state_q     <= StAnswer;
                        time_left_q <= AnswerSecs;
                        tick_q      <= '0;
                        buzz_q      <= BuzzLoad;
                    end else if (elig_mask == 4'd0) begin
                        locked_q <= 4'd0;
                        state_q  <= StIdle;
                    end
                end
                StAnswer: begin
                    if (host_cancel_i) begin
                        locked_q    <= 4'd0;
                        winner_q    <= 3'd0;
                        time_left_q <= 4'd0;
                        tick_q      <= '0;
                        state_q     <= StIdle;
                    end else if (host_correct_i) begin
                        score_q[win_sel] <= score_up[6:0];
                        locked_q         <= 4'd0;
                        winner_q         <= 3'd0;
                        time_left_q      <= 4'd0;
                        tick_q           <= '0;
                        state_q          <= StIdle;
                    end else if (host_wrong_i || timeout) begin
                        score_q[win_sel] <= score_dn[6:0];
                        winner_q         <= 3'd0;
                        time_left_q      <= 4'd0;
                        tick_q           <= '0;
                        if ((valid_mask & ~locked_after_wrong) != 4'd0) begin
                            locked_q <= locked_after_wrong;
                            state_q  <= StArmed;
                        end else begin
                            locked_q <= 4'd0;
                            state_q  <= StIdle;
                        end
                    end else if (tick_wrap) begin
                        tick_q      <= '0;
                        time_left_q <= time_left_q - 4'd1;
                    end else begin
                        tick_q <= tick_q + TickW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign state_o         = state_q;
    assign winner_o        = winner_q;
    assign locked_o        = locked_q;
    assign time_left_o     = time_left_q;
    assign player1_score_o = score_q[0];
    assign player2_score_o = score_q[1];
    assign player3_score_o = score_q[2];
    assign player4_score_o = score_q[3];
    assign buzzer_o        = (buzz_q != '0);
    assign led_o           = {7'd0, (state_q == StArmed), 4'd0, locked_q, 4'd0, win_onehot};

endmodule

// File: tb/tb_quiz_buzz_arbiter.sv
// Scoreboard bench for quiz_buzz_arbiter: a rule-level model predicts every
// cycle's outputs; a monitor pops and compares them after each clock edge.
module tb_quiz_buzz_arbiter;

    localparam int TPS  = 4;
    localparam int ANS  = 2;
    localparam int CP   = 2;
    localparam int WP   = 1;
    localparam int BUZZ = 5;

    typedef struct packed {
        logic [1:0]  st;
        logic [2:0]  win;
        logic [3:0]  lck;
        logic [3:0]  tl;
        logic [6:0]  s1;
        logic [6:0]  s2;
        logic [6:0]  s3;
        logic [6:0]  s4;
        logic [23:0] led;
        logic        buz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  player_count = 3'd4;
    logic [3:0]  player_press = 4'd0;
    logic        host_start = 1'b0;
    logic        host_correct = 1'b0;
    logic        host_wrong = 1'b0;
    logic        host_cancel = 1'b0;
    logic        clear_scores = 1'b0;
    logic [1:0]  state;
    logic [2:0]  winner;
    logic [3:0]  locked;
    logic [3:0]  time_left;
    logic [6:0]  s1, s2, s3, s4;
    logic [23:0] led;
    logic        buzzer;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state, at the level of the game rules.
    int m_state, m_winner, m_tl, m_tick, m_buzz;
    int m_score [1:4];
    bit m_lock  [1:4];

    quiz_buzz_arbiter #(
        .TICKS_PER_SEC(TPS),
        .ANSWER_SECS  (ANS),
        .CORRECT_PTS  (CP),
        .WRONG_PTS    (WP),
        .BUZZ_CYCLES  (BUZZ)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .player_count_i (player_count),
        .player_press_i (player_press),
        .host_start_i   (host_start),
        .host_correct_i (host_correct),
        .host_wrong_i   (host_wrong),
        .host_cancel_i  (host_cancel),
        .clear_scores_i (clear_scores),
        .state_o        (state),
        .winner_o       (winner),
        .locked_o       (locked),
        .time_left_o    (time_left),
        .player1_score_o(s1),
        .player2_score_o(s2),
        .player3_score_o(s3),
        .player4_score_o(s4),
        .led_o          (led),
        .buzzer_o       (buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_locks();
        for (int i = 1; i <= 4; i++) m_lock[i] = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0; m_winner = 0; m_tl = 0; m_tick = 0; m_buzz = 0;
        clear_locks();
        for (int i = 1; i <= 4; i++) m_score[i] = 0;
    endtask

    function automatic bit any_elig(input int n);
        for (int i = 1; i <= n; i++) if (!m_lock[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic r, input logic en, input logic [2:0] pc,
                              input logic [3:0] pr, input logic st, input logic co,
                              input logic wr, input logic ca, input logic cl);
        int n;
        int first;
        bit expire;
        if (r) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_state = 0; m_winner = 0; m_tl = 0; m_tick = 0; m_buzz = 0;
            clear_locks();
            return;
        end
        n = (pc == 3'd0) ? 1 : (pc > 3'd4) ? 4 : int'(pc);
        if (m_buzz > 0) m_buzz--;
        case (m_state)
            0: begin
                if (cl) for (int i = 1; i <= 4; i++) m_score[i] = 0;
                if (st) m_state = 1;
                else for (int i = 1; i <= n; i++) if (pr[i-1]) m_lock[i] = 1'b1;
            end
            1: begin
                if (ca) begin
                    clear_locks();
                    m_state = 0;
                end else begin
                    first = 0;
                    for (int i = n; i >= 1; i--) if (pr[i-1] && !m_lock[i]) first = i;
                    if (first != 0) begin
                        m_winner = first; m_state = 2; m_tl = ANS; m_tick = 0; m_buzz = BUZZ;
                    end else if (!any_elig(n)) begin
                        clear_locks();
                        m_state = 0;
                    end
                end
            end
            default: begin
                expire = (m_tick == TPS - 1) && (m_tl == 1);
                if (ca) begin
                    clear_locks();
                    m_winner = 0; m_tl = 0; m_tick = 0; m_state = 0;
                end else if (co) begin
                    m_score[m_winner] = (m_score[m_winner] + CP > 99) ? 99 : m_score[m_winner] + CP;
                    clear_locks();
                    m_winner = 0; m_tl = 0; m_tick = 0; m_state = 0;
                end else if (wr || expire) begin
                    m_score[m_winner] = (m_score[m_winner] < WP) ? 0 : m_score[m_winner] - WP;
                    m_lock[m_winner] = 1'b1;
                    m_winner = 0; m_tl = 0; m_tick = 0;
                    if (any_elig(n)) m_state = 1;
                    else begin
                        clear_locks();
                        m_state = 0;
                    end
                end else if (m_tick == TPS - 1) begin
                    m_tick = 0;
                    m_tl--;
                end else begin
                    m_tick++;
                end
            end
        endcase
    endtask

    function automatic exp_t snap();
        exp_t e;
        logic [23:0] l;
        l = '0;
        if (m_winner != 0) l[m_winner-1] = 1'b1;
        for (int i = 1; i <= 4; i++) l[7+i] = m_lock[i];
        if (m_state == 1) l[16] = 1'b1;
        e.st  = 2'(m_state);
        e.win = 3'(m_winner);
        e.lck = {m_lock[4], m_lock[3], m_lock[2], m_lock[1]};
        e.tl  = 4'(m_tl);
        e.s1  = 7'(m_score[1]);
        e.s2  = 7'(m_score[2]);
        e.s3  = 7'(m_score[3]);
        e.s4  = 7'(m_score[4]);
        e.led = l;
        e.buz = (m_buzz != 0);
        return e;
    endfunction

    task automatic drive(input logic r, input logic en, input logic [2:0] pc,
                         input logic [3:0] pr, input logic st, input logic co,
                         input logic wr, input logic ca, input logic cl);
        @(negedge clk);
        rst = r; enable = en; player_count = pc; player_press = pr;
        host_start = st; host_correct = co; host_wrong = wr; host_cancel = ca;
        clear_scores = cl;
        model_step(r, en, pc, pr, st, co, wr, ca, cl);
        exp_q.push_back(snap());
    endtask

    // Shorthands with rst=0, enable=1.
    task automatic go(input logic [2:0] pc, input logic [3:0] pr, input logic st,
                      input logic co, input logic wr, input logic ca);
        drive(1'b0, 1'b1, pc, pr, st, co, wr, ca, 1'b0);
    endtask

    task automatic idle(input logic [2:0] pc, input int n);
        for (int i = 0; i < n; i++) go(pc, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("state", int'(state), int'(mon_e.st));
            chk("winner", int'(winner), int'(mon_e.win));
            chk("locked", int'(locked), int'(mon_e.lck));
            chk("time_left", int'(time_left), int'(mon_e.tl));
            chk("score1", int'(s1), int'(mon_e.s1));
            chk("score2", int'(s2), int'(mon_e.s2));
            chk("score3", int'(s3), int'(mon_e.s3));
            chk("score4", int'(s4), int'(mon_e.s4));
            chk("led", int'(led), int'(mon_e.led));
            chk("buzzer", int'(buzzer), int'(mon_e.buz));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_rst, r_en, r_st, r_co, r_wr, r_ca, r_cl;
        logic [2:0]  r_pc;
        logic [3:0]  r_pr;
        model_reset();
        drive(1'b1, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3'd3, 2);

        // Press alongside host_start is ignored; the next press locks in player 2.
        go(3'd3, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("lockin_state", int'(state), 2);
        chk("lockin_winner", int'(winner), 2);
        chk("lockin_buzzer", int'(buzzer), 1);
        chk("lockin_led", int'(led[3:0]), 2);
        go(3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Player 2 climbs to 98, then saturates at 99.
        for (int k = 0; k < 48; k++) begin
            go(3'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            go(3'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
            go(3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        settle();
        chk("score_98", int'(s2), 98);
        go(3'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("score_sat99", int'(s2), 99);
        chk("sat_state", int'(state), 0);
        chk("sat_locked", int'(locked), 0);

        // Timeout on player 3 after ANS*TPS cycles.
        go(3'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd3, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("tl_start", int'(time_left), 2);
        idle(3'd3, 4);
        settle();
        chk("tl_one", int'(time_left), 1);
        idle(3'd3, 4);
        settle();
        chk("timeout_state", int'(state), 1);
        chk("timeout_locked", int'(locked), 4);
        chk("timeout_score", int'(s3), 0);
        go(3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Foul then wrong answer exhausts both players.
        go(3'd2, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd2, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("exhaust_state", int'(state), 0);
        chk("exhaust_locked", int'(locked), 0);
        chk("exhaust_score", int'(s2), 98);

        // Judgement priority.
        go(3'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd4, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'd4, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        go(3'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd4, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        settle();
        chk("prio_score4", int'(s4), 2);

        // enable low during ARMED keeps scores.
        go(3'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 3'd4, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("dis_state", int'(state), 0);
        chk("dis_score2", int'(s2), 98);

        // Async reset mid-ANSWER clears outputs without waiting for an edge.
        go(3'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        go(3'd4, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_buzzer", int'(buzzer), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_score2", int'(s2), 0);
        chk("rst_score4", int'(s4), 0);

        for (int k = 0; k < 3000; k++) begin
            r_rst = ($urandom_range(0, 499) == 0);
            r_en  = ($urandom_range(0, 39) != 0);
            r_pc  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(0, 7)) : player_count;
            r_pr  = 4'd0;
            for (int b = 0; b < 4; b++) r_pr[b] = ($urandom_range(0, 5) == 0);
            r_st  = ($urandom_range(0, 7) == 0);
            r_co  = ($urandom_range(0, 9) == 0);
            r_wr  = ($urandom_range(0, 9) == 0);
            r_ca  = ($urandom_range(0, 29) == 0);
            r_cl  = ($urandom_range(0, 39) == 0);
            drive(r_rst, r_en, r_pc, r_pr, r_st, r_co, r_wr, r_ca, r_cl);
        end
        drive(1'b0, 1'b1, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
